// File: rtl/csdt2_pcpi_issue_if.sv
// Bus bundle for the PCPI issue controller.
// Carries three groups of signals:
//   - core request:   req_valid/req_insn/req_rs1/req_rs2 in, req_ready/busy out
//   - core response:  resp_valid/resp_wr/resp_rd/resp_illegal
//   - PCPI bus:       pcpi_valid/pcpi_insn/pcpi_rs1/pcpi_rs2 out,
//                     pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready return
// Modports:
//   - master: the issue controller, which initiates on PCPI.
//   - slave:  the environment, i.e. the core plus the OR-ed responders.
interface csdt2_pcpi_issue_if;
    logic        req_valid;
    logic [31:0] req_insn;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        req_ready;
    logic        busy;

    logic        resp_valid;
    logic        resp_wr;
    logic [31:0] resp_rd;
    logic        resp_illegal;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        input  req_valid, req_insn, req_rs1, req_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output req_ready, busy,
        output resp_valid, resp_wr, resp_rd, resp_illegal,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );

    modport slave (
        output req_valid, req_insn, req_rs1, req_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  req_ready, busy,
        input  resp_valid, resp_wr, resp_rd, resp_illegal,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );
endinterface

// File: rtl/csdt2_pcpi_issue.sv
// Initiator-side PCPI controller.
// Takes one coprocessor instruction at a time from the core and drives it onto the PCPI request
// bus. It then waits for a responder to finish with pcpi_ready and returns a one-cycle writeback
// pulse. If no responder claims the instruction, or keeps it alive with pcpi_wait, within the
// timeout window, it returns an illegal-instruction pulse instead.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - csdt2_pcpi_issue_if.master (core request/response and PCPI bus)
module csdt2_pcpi_issue #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                       clk,
    input logic                       reset,
    csdt2_pcpi_issue_if.master        bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pcpi_valid_q, pcpi_valid_d;
    logic [31:0]     pcpi_insn_q, pcpi_insn_d;
    logic [31:0]     pcpi_rs1_q, pcpi_rs1_d;
    logic [31:0]     pcpi_rs2_q, pcpi_rs2_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_wr_q, resp_wr_d;
    logic            resp_illegal_q, resp_illegal_d;
    logic [31:0]     resp_rd_q, resp_rd_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pcpi_valid_d   = pcpi_valid_q;
        pcpi_insn_d    = pcpi_insn_q;
        pcpi_rs1_d     = pcpi_rs1_q;
        pcpi_rs2_d     = pcpi_rs2_q;
        // Response fields are pulses: cleared unless this edge completes a transaction.
        resp_valid_d   = 1'b0;
        resp_wr_d      = 1'b0;
        resp_illegal_d = 1'b0;
        resp_rd_d      = '0;

        unique case (state_q)
            StIdle: begin
                // Responder return signals are deliberately ignored here (stray late responses).
                if (bus.req_valid) begin
                    pcpi_insn_d  = bus.req_insn;
                    pcpi_rs1_d   = bus.req_rs1;
                    pcpi_rs2_d   = bus.req_rs2;
                    pcpi_valid_d = 1'b1;
                    cnt_d        = CntLoad;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (bus.pcpi_ready) begin
                    resp_valid_d = 1'b1;
                    resp_wr_d    = bus.pcpi_wr;
                    resp_rd_d    = bus.pcpi_wr ? bus.pcpi_rd : '0;
                    pcpi_valid_d = 1'b0;
                    state_d      = StIdle;
                end else if (bus.pcpi_wait) begin
                    cnt_d = CntLoad;
                end else if (cnt_q == '0) begin
                    resp_valid_d   = 1'b1;
                    resp_illegal_d = 1'b1;
                    pcpi_valid_d   = 1'b0;
                    state_d        = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            pcpi_valid_q   <= 1'b0;
            pcpi_insn_q    <= '0;
            pcpi_rs1_q     <= '0;
            pcpi_rs2_q     <= '0;
            resp_valid_q   <= 1'b0;
            resp_wr_q      <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_rd_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pcpi_valid_q   <= pcpi_valid_d;
            pcpi_insn_q    <= pcpi_insn_d;
            pcpi_rs1_q     <= pcpi_rs1_d;
            pcpi_rs2_q     <= pcpi_rs2_d;
            resp_valid_q   <= resp_valid_d;
            resp_wr_q      <= resp_wr_d;
            resp_illegal_q <= resp_illegal_d;
            resp_rd_q      <= resp_rd_d;
        end
    end

    // The completion cycle is already IDLE, so a new request can be taken at its end.
    assign bus.req_ready    = (state_q == StIdle);
    assign bus.busy         = (state_q == StBusy);
    assign bus.pcpi_valid   = pcpi_valid_q;
    assign bus.pcpi_insn    = pcpi_insn_q;
    assign bus.pcpi_rs1     = pcpi_rs1_q;
    assign bus.pcpi_rs2     = pcpi_rs2_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_wr      = resp_wr_q;
    assign bus.resp_illegal = resp_illegal_q;
    assign bus.resp_rd      = resp_rd_q;
endmodule
